// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, derived totals and sync bounds, plus a small
// window helper. The pixel renderer imports this as well.
package vga_timing_pkg;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] coord_t;

  // 640x480 @ 60 Hz with a 25 MHz pixel rate derived from a 100 MHz clock
  localparam int DIV_DEF    = 4;
  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  localparam int H_TOTAL_DEF  = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF  = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int HS_START_DEF = H_VIS_DEF + H_FP_DEF;
  localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
  localparam int VS_START_DEF = V_VIS_DEF + V_FP_DEF;
  localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

  // True when lo <= v < hi
  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_pix_en_div.sv
// Pixel-enable divider: free-running 0..DIV-1 counter that only advances
// while en is high, and flags the last count as a one-clk tick.
module pix_en_div
  import vga_timing_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  logic [DW-1:0] cnt_q, cnt_d;

  // Next count and tick; holding en low freezes the count mid-period
  always_comb begin
    cnt_d = cnt_q;
    tick  = en && !rst && (cnt_q == LAST);
    if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + DW'(1);
    end
  end

  // Count register, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: pixel/line counters on clk qualified by pix_tick,
// registered sync/blanking derived from the next counter values so they
// line up with pixel_x/pixel_y, and registered wrap pulses.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int DIV    = DIV_DEF,
  parameter int H_VIS  = H_VIS_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_VIS  = V_VIS_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       pix_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_end,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VISC = coord_t'(H_VIS);
  localparam coord_t V_VISC = coord_t'(V_VIS);
  localparam coord_t HS_LO  = coord_t'(H_VIS + H_FP);
  localparam coord_t HS_HI  = coord_t'(H_VIS + H_FP + H_SYNC);
  localparam coord_t VS_LO  = coord_t'(V_VIS + V_FP);
  localparam coord_t VS_HI  = coord_t'(V_VIS + V_FP + V_SYNC);

  logic   tick;
  coord_t x_q, x_d, y_q, y_d;
  logic   hs_q, hs_d, vs_q, vs_d, von_q, von_d;
  logic   le_q, le_d, fs_q, fs_d;

  pix_en_div #(.DIV(DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // Counter advance on tick, wrap pulses, and sync/blank from next position
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    le_d = 1'b0;
    fs_d = 1'b0;
    if (tick) begin
      if (x_q == H_LAST) begin
        x_d  = '0;
        le_d = 1'b1;
        if (y_q == V_LAST) begin
          y_d  = '0;
          fs_d = 1'b1;
        end else begin
          y_d = y_q + coord_t'(1);
        end
      end else begin
        x_d = x_q + coord_t'(1);
      end
    end
    hs_d  = !in_window(x_d, HS_LO, HS_HI);
    vs_d  = !in_window(y_d, VS_LO, VS_HI);
    von_d = (x_d < H_VISC) && (y_d < V_VISC);
  end

  // State registers; reset parks at the last position so the first tick lands on (0,0)
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= H_LAST;
      y_q   <= V_LAST;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      von_q <= 1'b0;
      le_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      le_q <= le_d;
      fs_q <= fs_d;
      if (en) begin
        x_q   <= x_d;
        y_q   <= y_d;
        hs_q  <= hs_d;
        vs_q  <= vs_d;
        von_q <= von_d;
      end
    end
  end

  assign pix_tick    = tick;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign video_on    = von_q;
  // Pulses are suppressed while the block is paused
  assign line_end    = le_q & en;
  assign frame_start = fs_q & en;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: one instance with default 640x480 timing and one
// with a tiny raster so whole frames fit in a short run. Both are checked
// every clk against an arithmetic model (position = tick count mod frame).
module tb_vga_timing_ctrl;

  typedef struct {
    int div;
    int hv; int hf; int hsy; int hb;
    int vv; int vf; int vsy; int vb;
  } cfg_t;

  typedef struct {
    logic r; logic e; logic tk;
    logic [9:0] x; logic [9:0] y;
    logic von; logic hs; logic vs; logic le; logic fs;
  } vec_t;

  localparam int B_DIV = 3;
  localparam int B_HV = 8, B_HF = 2, B_HS = 3, B_HB = 2;
  localparam int B_VV = 6, B_VF = 2, B_VS = 2, B_VB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_w [2];
  logic tick_w [2];
  logic [9:0] px_w [2];
  logic [9:0] py_w [2];
  logic hs_w [2], vs_w [2], von_w [2], le_w [2], fs_w [2];

  int errors = 0;
  int checks = 0;

  cfg_t   cfg [2];
  longint en_cnt [2];
  longint tick_cnt [2];
  bit     pl_q [2];
  bit     pf_q [2];

  // Clock
  always #5 clk = ~clk;

  vga_timing_ctrl u_dut_a (
    .clk(clk), .rst(rst), .en(en_w[0]), .pix_tick(tick_w[0]),
    .pixel_x(px_w[0]), .pixel_y(py_w[0]), .hsync(hs_w[0]), .vsync(vs_w[0]),
    .video_on(von_w[0]), .line_end(le_w[0]), .frame_start(fs_w[0])
  );

  vga_timing_ctrl #(
    .DIV(B_DIV), .H_VIS(B_HV), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_VIS(B_VV), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB)
  ) u_dut_b (
    .clk(clk), .rst(rst), .en(en_w[1]), .pix_tick(tick_w[1]),
    .pixel_x(px_w[1]), .pixel_y(py_w[1]), .hsync(hs_w[1]), .vsync(vs_w[1]),
    .video_on(von_w[1]), .line_end(le_w[1]), .frame_start(fs_w[1])
  );

  // ---------------- reference model ----------------
  function automatic int ht(int i);
    return cfg[i].hv + cfg[i].hf + cfg[i].hsy + cfg[i].hb;
  endfunction
  function automatic int vt(int i);
    return cfg[i].vv + cfg[i].vf + cfg[i].vsy + cfg[i].vb;
  endfunction
  function automatic longint pos(int i);
    longint f;
    f = longint'(ht(i)) * longint'(vt(i));
    return (tick_cnt[i] + f - 1) % f;
  endfunction
  function automatic int mx(int i);
    return int'(pos(i) % longint'(ht(i)));
  endfunction
  function automatic int my(int i);
    return int'(pos(i) / longint'(ht(i)));
  endfunction
  function automatic bit m_hs(int i);
    int x;
    x = mx(i);
    return !((x >= cfg[i].hv + cfg[i].hf) && (x < cfg[i].hv + cfg[i].hf + cfg[i].hsy));
  endfunction
  function automatic bit m_vs(int i);
    int y;
    y = my(i);
    return !((y >= cfg[i].vv + cfg[i].vf) && (y < cfg[i].vv + cfg[i].vf + cfg[i].vsy));
  endfunction
  function automatic bit m_von(int i);
    return (mx(i) < cfg[i].hv) && (my(i) < cfg[i].vv);
  endfunction
  function automatic bit m_tick(int i);
    return (rst === 1'b0) && (en_w[i] === 1'b1) &&
           ((en_cnt[i] % longint'(cfg[i].div)) == longint'(cfg[i].div - 1));
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", nm, i, $time, act, exp);
    end
  endtask

  // ---------------- driver: one clk ----------------
  task automatic cyc(input logic r, input logic ea, input logic eb);
    bit t;
    @(negedge clk);
    rst = r;
    en_w[0] = ea;
    en_w[1] = eb;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("pix_tick", i, tick_w[i], m_tick(i));
      chk("pixel_x", i, px_w[i], mx(i));
      chk("pixel_y", i, py_w[i], my(i));
      chk("hsync", i, hs_w[i], m_hs(i));
      chk("vsync", i, vs_w[i], m_vs(i));
      chk("video_on", i, von_w[i], m_von(i));
      chk("line_end", i, le_w[i], en_w[i] && pl_q[i]);
      chk("frame_start", i, fs_w[i], en_w[i] && pf_q[i]);
    end
    // model update for the coming edge
    for (int i = 0; i < 2; i++) begin
      t = m_tick(i);
      if (rst) begin
        en_cnt[i] = 0;
        tick_cnt[i] = 0;
        pl_q[i] = 0;
        pf_q[i] = 0;
      end else begin
        if (en_w[i]) en_cnt[i]++;
        if (t) tick_cnt[i]++;
        pl_q[i] = t && (mx(i) == 0);
        pf_q[i] = t && (pos(i) == 0);
      end
    end
  endtask

  function automatic vec_t mk(logic r, logic tk, int x, int y, logic von, logic le, logic fs);
    vec_t v;
    v.r = r; v.e = 1'b1; v.tk = tk; v.x = 10'(x); v.y = 10'(y);
    v.von = von; v.hs = 1'b1; v.vs = 1'b1; v.le = le; v.fs = fs;
    return v;
  endfunction

  vec_t vt_tab [10];

  initial begin
    int hs_low, von_n, le_n, first_hs, fs_n, wraps, ymax, vs_low, guard, prev_y;
    int sx, sy;
    bit shs, svs, svon;

    cfg[0] = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
    cfg[1] = '{B_DIV, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB};
    for (int i = 0; i < 2; i++) begin
      en_cnt[i] = 0; tick_cnt[i] = 0; pl_q[i] = 0; pf_q[i] = 0;
    end
    en_w[0] = 1'b1;
    en_w[1] = 1'b1;

    // Reset-release sequence for the default instance
    vt_tab[0] = mk(1, 0, 799, 524, 0, 0, 0);
    vt_tab[1] = mk(0, 0, 799, 524, 0, 0, 0);
    vt_tab[2] = mk(0, 0, 799, 524, 0, 0, 0);
    vt_tab[3] = mk(0, 0, 799, 524, 0, 0, 0);
    vt_tab[4] = mk(0, 1, 799, 524, 0, 0, 0);
    vt_tab[5] = mk(0, 0, 0, 0, 1, 1, 1);
    vt_tab[6] = mk(0, 0, 0, 0, 1, 0, 0);
    vt_tab[7] = mk(0, 0, 0, 0, 1, 0, 0);
    vt_tab[8] = mk(0, 1, 0, 0, 1, 0, 0);
    vt_tab[9] = mk(0, 0, 1, 0, 1, 0, 0);

    repeat (2) @(posedge clk);

    for (int k = 0; k < 10; k++) begin
      cyc(vt_tab[k].r, vt_tab[k].e, 1'b1);
      chk("tab_tick", k, tick_w[0], vt_tab[k].tk);
      chk("tab_x", k, px_w[0], vt_tab[k].x);
      chk("tab_y", k, py_w[0], vt_tab[k].y);
      chk("tab_von", k, von_w[0], vt_tab[k].von);
      chk("tab_hs", k, hs_w[0], vt_tab[k].hs);
      chk("tab_vs", k, vs_w[0], vt_tab[k].vs);
      chk("tab_le", k, le_w[0], vt_tab[k].le);
      chk("tab_fs", k, fs_w[0], vt_tab[k].fs);
    end

    // One full line from the first pixel of the frame
    cyc(1, 1, 1);
    repeat (4) cyc(0, 1, 1);
    hs_low = 0; von_n = 0; le_n = 0; first_hs = -1;
    for (int k = 0; k < 3200; k++) begin
      cyc(0, 1, 1);
      if (hs_w[0] === 1'b0) begin
        hs_low++;
        if (first_hs < 0) first_hs = int'(px_w[0]);
      end
      if (von_w[0] === 1'b1) von_n++;
      if (le_w[0] === 1'b1) le_n++;
    end
    chk("line_hs_low_clks", 0, hs_low, 96 * 4);
    chk("line_hs_first_x", 0, first_hs, 656);
    chk("line_von_clks", 0, von_n, 640 * 4);
    chk("line_end_count", 0, le_n, 1);

    // Pause with the divider at 2
    guard = 0;
    while ((en_cnt[0] % 4) != 2 && guard < 8) begin
      cyc(0, 1, 1);
      guard++;
    end
    chk("align_div2", 0, int'(en_cnt[0] % 4), 2);
    sx = mx(0); sy = my(0); shs = m_hs(0); svs = m_vs(0); svon = m_von(0);
    for (int k = 0; k < 7; k++) begin
      cyc(0, 0, 1);
      chk("frz_x", 0, px_w[0], sx);
      chk("frz_y", 0, py_w[0], sy);
      chk("frz_hs", 0, hs_w[0], shs);
      chk("frz_vs", 0, vs_w[0], svs);
      chk("frz_von", 0, von_w[0], svon);
      chk("frz_tick", 0, tick_w[0], 0);
      chk("frz_le", 0, le_w[0], 0);
      chk("frz_fs", 0, fs_w[0], 0);
    end
    cyc(0, 1, 1);
    chk("resume_no_tick", 0, tick_w[0], 0);
    cyc(0, 1, 1);
    chk("resume_tick", 0, tick_w[0], 1);

    // Mid-line reset at pixel_x=700
    guard = 0;
    while (mx(0) != 700 && guard < 3300) begin
      cyc(0, 1, 1);
      guard++;
    end
    chk("reach_x700", 0, mx(0), 700);
    cyc(1, 1, 1);
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 1, 1);
      if (k == 1) begin
        chk("rst_x", 0, px_w[0], 799);
        chk("rst_y", 0, py_w[0], 524);
        chk("rst_hs", 0, hs_w[0], 1);
        chk("rst_vs", 0, vs_w[0], 1);
        chk("rst_von", 0, von_w[0], 0);
      end
      chk("rst_seq_tick", k, tick_w[0], (k == 4) ? 1 : 0);
      chk("rst_seq_fs", k, fs_w[0], (k == 5) ? 1 : 0);
    end

    // Full frame plus wrap on the small instance
    cyc(1, 1, 1);
    fs_n = 0; wraps = 0; ymax = 0; vs_low = 0; prev_y = B_VV + B_VF + B_VS + B_VB - 1;
    for (int k = 0; k < 545; k++) begin
      cyc(0, 1, 1);
      if (fs_w[1] === 1'b1) fs_n++;
      if (vs_w[1] === 1'b0) vs_low++;
      if (int'(py_w[1]) > ymax) ymax = int'(py_w[1]);
      if (prev_y == B_VV + B_VF + B_VS + B_VB - 1 && py_w[1] === 10'd0) wraps++;
      prev_y = int'(py_w[1]);
    end
    chk("frame_fs_count", 1, fs_n, 2);
    chk("frame_vs_low_clks", 1, vs_low, B_VS * (B_HV + B_HF + B_HS + B_HB) * B_DIV);
    chk("frame_ymax", 1, ymax, B_VV + B_VF + B_VS + B_VB - 1);
    chk("frame_wraps", 1, wraps, 2);

    // Random enable and occasional reset, both instances
    for (int k = 0; k < 20000; k++) begin
      cyc(($urandom_range(0, 999) == 0), ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameter DIV, default 4: system clocks per pixel; 100 MHz clk gives a 25 MHz pixel rate.
REQ-002 Parameter H_VIS/H_FP/H_SYNC/H_BP, default 640/16/96/48: horizontal timing in pixels.
REQ-003 Parameter V_VIS/V_FP/V_SYNC/V_BP, default 480/10/2/33: vertical timing in lines.
REQ-004 Port clk  input  1: single system clock; all logic on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous and active-high.
REQ-006 Port en  input  1: run enable; low freezes all state.
REQ-007 Port pix_tick  output  1: one-clk pixel enable, asserted once per DIV clks.
REQ-008 Port pixel_x  output  10: horizontal counter, 0..H_TOTAL-1.
REQ-009 Port pixel_y  output  10: vertical counter, 0..V_TOTAL-1.
REQ-010 Port hsync  output  1: horizontal sync, active-low.
REQ-011 Port vsync  output  1: vertical sync, active-low.
REQ-012 Port video_on  output  1: high while the pixel is inside the visible area.
REQ-013 Port line_end  output  1: one-clk pulse when pixel_x wraps to 0.
REQ-014 Port frame_start  output  1: one-clk pulse when (pixel_x,pixel_y) wraps to (0,0).

Function
REQ-015 Totals SHALL be H_TOTAL=H_VIS+H_FP+H_SYNC+H_BP (default 800) and V_TOTAL=V_VIS+V_FP+V_SYNC+V_BP (default 525).
REQ-016 The divider SHALL count 0..DIV-1 while en=1; pix_tick=1 exactly in the clk where the divider is at DIV-1; the divider then wraps to 0.
REQ-017 Each pix_tick SHALL advance pixel_x by 1, wrapping from H_TOTAL-1 to 0.
REQ-018 When pixel_x wraps, pixel_y SHALL advance by 1 in the same tick, wrapping from V_TOTAL-1 to 0.
REQ-019 hsync, vsync and video_on SHALL be registers, computed from the next counter values, so they always match the current pixel_x and pixel_y.
REQ-020 hsync SHALL be 0 iff H_VIS+H_FP <= pixel_x < H_VIS+H_FP+H_SYNC (default 656..751).
REQ-021 vsync SHALL be 0 iff V_VIS+V_FP <= pixel_y < V_VIS+V_FP+V_SYNC (default 490..491).
REQ-022 video_on SHALL be 1 iff pixel_x < H_VIS and pixel_y < V_VIS.
REQ-023 line_end and frame_start SHALL be registered pulses, high for the single clk after the tick that produced the wrap, and low otherwise.
REQ-024 While en=0, the divider, counters and all outputs SHALL hold; pix_tick, line_end and frame_start SHALL be 0.
REQ-025 When en returns to 1, the divider SHALL resume from its held value, with no extra or lost tick.
REQ-026 Counter arithmetic SHALL be unsigned, 10 bits wide; no out-of-range value SHALL ever appear.

Reset
REQ-027 While rst=1, the block SHALL hold: divider=0, pixel_x=H_TOTAL-1, pixel_y=V_TOTAL-1, hsync=1, vsync=1, video_on=0, pix_tick=0, line_end=0, frame_start=0.
REQ-028 Reset SHALL take priority over en.
REQ-029 Reset asserted mid-frame SHALL return the block to the REQ-027 values on the next clk edge.
REQ-030 With en=1 after reset release, the first pix_tick SHALL occur in the DIV-th clk.
REQ-031 That first tick SHALL yield (0,0), video_on=1, frame_start and line_end pulses in the following clk.

Structure
REQ-032 Timing defaults and derived totals/sync bounds SHALL live in shared package vga_timing_pkg, for reuse by the pixel renderer.
REQ-033 The divider SHALL be sub-module pix_en_div (ports clk, rst, en, tick).
REQ-034 The block SHALL generate no derived clock; downstream logic SHALL run on clk qualified by pix_tick.

Verification
REQ-035 Release rst with en=1 -> pix_tick at clks 4, 8, 12, ...; at clk 5, pixel_x=0, pixel_y=0, video_on=1, frame_start=1.
REQ-036 Run one line -> hsync low for exactly 96 ticks starting at pixel_x=656; line_end once per 800 ticks; video_on high for 640 ticks per visible line.
REQ-037 Run a full frame (420000 ticks) -> vsync low on lines 490-491 only; frame_start exactly once; pixel_y reaches 524 then wraps to 0.
REQ-038 Drop en for 7 clks at divider=2 -> all outputs frozen, no pulses; the next tick arrives 1 clk after en=1.
REQ-039 Assert rst for 1 clk at pixel_x=700, pixel_y=300 -> next clk shows (799,524), hsync=vsync=1, video_on=0; REQ-035 sequence repeats.
REQ-040 Check every clk -> pixel_x < 800, pixel_y < 525, and video_on/hsync/vsync consistent with REQ-020..REQ-022.
